// File: rtl/alu_pkg.sv
// Shared types and defaults for the 8-bit logic unit front end.
package alu_pkg;

  // Default operand width; each bit feeds one logic-unit input A1..A8.
  localparam int DEFAULT_WIDTH = 8;

  // Serial loader control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } loader_state_t;

endpackage : alu_pkg

// File: rtl/serial_shift_register.sv
// LSB-first serial-in / parallel-out shift register with synchronous clear.
module serial_shift_register
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next value: clear wins over shift; new bit enters at the MSB so that
  // after WIDTH shifts the first bit received sits in bit 0.
  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (en) begin
      sr_d = {d, sr_q[WIDTH-1:1]};
    end
  end

  // Shift register storage with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; reset is checked inside the clocked block, so it is
  // synchronous and only takes effect on a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule : serial_shift_register

// File: rtl/serial_operand_loader.sv
// Assembles an operand from an LSB-first serial stream and holds it behind
// a valid/ready handshake until the downstream logic unit accepts it.
module serial_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             overrun_q, overrun_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             sr_clr;
  logic             sr_en;
  logic [WIDTH-1:0] sr_q;

  // The final shift pushes bit 0 of the old contents out; it is never used.
  logic             sr_lsb_unused;
  assign sr_lsb_unused = sr_q[0];

  serial_shift_register #(
    .WIDTH (WIDTH)
  ) u_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sr_clr),
    .en    (sr_en),
    .d     (serial_in),
    .q     (sr_q)
  );

  // Next-state, counter, operand capture and overrun decisions.
  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    overrun_d = overrun_q;
    sr_clr    = 1'b0;
    sr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Strobes while idle are simply ignored.
        if (start) begin
          state_d   = LOAD;
          cnt_d     = '0;
          sr_clr    = 1'b1;
          overrun_d = 1'b0;
        end
      end

      LOAD: begin
        if (start) begin
          // Restart drops any partial frame and a same-cycle bit.
          cnt_d     = '0;
          sr_clr    = 1'b1;
          overrun_d = 1'b0;
        end else if (bit_valid) begin
          sr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            operand_d = {serial_in, sr_q[WIDTH-1:1]};
            state_d   = HOLD;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          // Accept edge: any strobe now is dropped silently.
          cnt_d = '0;
          if (start) begin
            state_d   = LOAD;
            sr_clr    = 1'b1;
            overrun_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (bit_valid) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Status flags are registered from the next state so they line up with
    // the state they describe and never depend on inputs combinationally.
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d == LOAD);
  end

  // Control and data registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      operand_q   <= '0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      operand_q   <= operand_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign operand   = operand_q;
  assign bit_count = cnt_q;
  assign overrun   = overrun_q;

endmodule : serial_operand_loader

// File: tb/tb_serial_operand_loader.sv
// Directed self-checking bench for serial_operand_loader.
module tb_serial_operand_loader;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             bit_valid;
  logic             serial_in;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  serial_operand_loader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .operand   (operand),
    .busy      (busy),
    .bit_count (bit_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Send WIDTH bits LSB first with 'gap' idle cycles between strobes.
  task automatic send_word(input logic [WIDTH-1:0] w, input int gap);
    for (int i = 0; i < WIDTH; i++) begin
      bit_valid = 1'b1;
      serial_in = w[i];
      tick();
      bit_valid = 1'b0;
      serial_in = 1'b0;
      if (i < WIDTH - 1) repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if ({out_valid, busy, overrun} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got v/b/o=%b%b%b want 000", out_valid, busy, overrun);
    end
    total++;
    if (operand !== 8'h00 || bit_count !== 4'd0) begin
      bad++;
      $display("FAIL reset_data: got op=%h cnt=%0d want 00/0", operand, bit_count);
    end
  endtask

  task automatic test_basic();
    pulse_start();
    total++;
    if (busy !== 1'b1 || bit_count !== 4'd0) begin
      bad++;
      $display("FAIL basic_start: got busy=%b cnt=%0d want 1/0", busy, bit_count);
    end
    // Bits 1,0,0,1,1,0,0,1 in arrival order form 8'b1001_1001.
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1;
      serial_in = 1'(8'h99 >> i);
      tick();
    end
    total++;
    if (out_valid !== 1'b0 || bit_count !== 4'd7) begin
      bad++;
      $display("FAIL basic_seven: got v=%b cnt=%0d want 0/7", out_valid, bit_count);
    end
    serial_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || operand !== 8'h99) begin
      bad++;
      $display("FAIL basic_done: got v=%b op=%h want 1/99", out_valid, operand);
    end
    total++;
    if (bit_count !== 4'd8 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_count: got cnt=%0d busy=%b want 8/0", bit_count, busy);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || operand !== 8'h99 || bit_count !== 4'd0) begin
      bad++;
      $display("FAIL basic_accept: got v=%b op=%h cnt=%0d want 0/99/0", out_valid, operand, bit_count);
    end
  endtask

  task automatic test_gaps();
    pulse_start();
    send_word(8'hF0, 2);
    for (int s = 0; s < 3; s++) begin
      total++;
      if (out_valid !== 1'b1 || operand !== 8'hF0) begin
        bad++;
        $display("FAIL gaps_stall%0d: got v=%b op=%h want 1/f0", s, out_valid, operand);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b1 || operand !== 8'hF0) begin
      bad++;
      $display("FAIL gaps_pre_accept: got v=%b op=%h want 1/f0", out_valid, operand);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL gaps_accept: got v=%b busy=%b st=%0d want 0/0/IDLE", out_valid, busy, dut.state_q);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      serial_in = 1'b0;
      tick();
    end
    // Start wins over the same-cycle strobe.
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b0;
    total++;
    if (bit_count !== 4'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_count: got cnt=%0d busy=%b want 0/1", bit_count, busy);
    end
    send_word(8'hFF, 0);
    total++;
    if (out_valid !== 1'b1 || operand !== 8'hFF) begin
      bad++;
      $display("FAIL restart_word: got v=%b op=%h want 1/ff", out_valid, operand);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    pulse_start();
    send_word(8'h00, 0);
    bit_valid = 1'b1;
    serial_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    total++;
    if (overrun !== 1'b1 || operand !== 8'h00 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got o=%b op=%h v=%b want 1/00/1", overrun, operand, out_valid);
    end
    // Accept with a strobe present: no change to operand, overrun stays sticky.
    out_ready = 1'b1;
    bit_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    bit_valid = 1'b0;
    total++;
    if (overrun !== 1'b1 || operand !== 8'h00 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL overrun_sticky: got o=%b op=%h v=%b want 1/00/0", overrun, operand, out_valid);
    end
    pulse_start();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: got o=%b want 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      serial_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({out_valid, busy, overrun} !== 3'b000 || operand !== 8'h00 ||
        bit_count !== 4'd0 || dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL midreset: got v=%b b=%b o=%b op=%h cnt=%0d st=%0d want all 0/IDLE",
               out_valid, busy, overrun, operand, bit_count, dut.state_q);
    end
    // Strobe while idle is ignored and is not an overrun.
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    total++;
    if (overrun !== 1'b0 || bit_count !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_strobe: got o=%b cnt=%0d busy=%b want 0/0/0", overrun, bit_count, busy);
    end
    pulse_start();
    send_word(8'h3C, 1);
    total++;
    if (out_valid !== 1'b1 || operand !== 8'h3C) begin
      bad++;
      $display("FAIL midreset_word: got v=%b op=%h want 1/3c", out_valid, operand);
    end
  endtask

  task automatic test_back_to_back();
    // Start without ready is ignored in HOLD.
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || operand !== 8'h3C) begin
      bad++;
      $display("FAIL hold_start_ignored: got v=%b busy=%b op=%h want 1/0/3c", out_valid, busy, operand);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || bit_count !== 4'd0 || operand !== 8'h3C) begin
      bad++;
      $display("FAIL b2b_load: got busy=%b v=%b cnt=%0d op=%h want 1/0/0/3c", busy, out_valid, bit_count, operand);
    end
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1;
      serial_in = 1'(8'hA5 >> i);
      tick();
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_early: got v=%b busy=%b want 0/1", out_valid, busy);
    end
    serial_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || operand !== 8'hA5 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_word: got v=%b op=%h busy=%b want 1/a5/0", out_valid, operand, busy);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    serial_in = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_restart();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_operand_loader

// File: doc/serial_operand_loader.md
# serial_operand_loader

Upstream stage of the 8-bit logic unit. It assembles an operand from a serial bitstream, one bit per strobe, LSB first. It then presents the operand in parallel, and its bits 0..7 drive the logic unit's inputs A1..A8. A valid/ready handshake holds the operand stable until the downstream consumer accepts it.

## Interface
- WIDTH, 8, operand width in bits (must be ≥2)
- CNT_W, $clog2(WIDTH+1), width of bit_count
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- start  in  1  begin new frame (single-cycle pulse)
- bit_valid  in  1  serial_in is valid this cycle
- serial_in  in  1  serial data bit, LSB first
- out_ready  in  1  downstream accepts operand
- out_valid  out  1  operand is complete and stable
- operand  out  WIDTH  assembled word; bit 0 → A1, bit WIDTH-1 → A8
- busy  out  1  high in LOAD state
- bit_count  out  CNT_W  bits captured in current frame
- overrun  out  1  sticky: strobe arrived while operand not yet accepted

## Operation
- FSM states: IDLE, LOAD, HOLD.
- Reset (rst_n=0 at edge):
  - state=IDLE, shift register=0, operand=0, bit_count=0.
  - out_valid=0, busy=0, overrun=0.
  - Reset overrides every other input, including mid-frame; partial data is discarded.
- IDLE:
  - start=1 → LOAD, with bit_count=0, shift register=0 and overrun cleared.
  - bit_valid is ignored and is not an overrun.
- LOAD:
  - bit_valid=1 → shift register takes {serial_in, sr[WIDTH-1:1]} and bit_count increments.
  - On the strobe with bit_count=WIDTH-1:
    - operand ← final shifted value.
    - bit_count ← WIDTH.
    - Next state is HOLD.
  - start=1 restarts the frame: bit_count=0, shift register=0, stay in LOAD. start has priority over a same-cycle bit_valid, and that bit is dropped.
  - bit_valid=0 holds all state (gaps of any length are allowed).
- HOLD:
  - out_valid=1 and operand is frozen.
  - out_ready=1 completes the transfer:
    - Next state is IDLE, or LOAD if start=1 in the same cycle.
    - bit_count returns to 0.
  - out_ready=0 and start=1: start is ignored.
  - bit_valid=1 while out_ready=0: the bit is dropped and overrun is set.
  - bit_valid=1 in the accept cycle: the bit is dropped, with no overrun.
- overrun:
  - Stays at 1 until reset or the next accepted start.
  - Affects no other outputs.
- operand keeps its last value after the transfer, until the next frame completes.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Latency:
  - out_valid rises in the cycle after the edge that samples the WIDTH-th strobe.
  - Minimum frame length is 1 (start) + WIDTH cycles to out_valid.
- Handshake: the transfer occurs on the edge where out_valid=1 and out_ready=1. out_valid falls in the next cycle.
- Sustained throughput: one operand per WIDTH+2 cycles (start, WIDTH strobes, accept), or WIDTH+1 cycles when start accompanies the accept.
- busy=1 in exactly the cycles with state=LOAD. out_valid and busy are never high together.

## Structure
- Package alu_pkg:
  - WIDTH default (8).
  - loader_state_t enum {IDLE, LOAD, HOLD}.
- Sub-module serial_shift_register:
  - Parameterised WIDTH; ports clk, rst_n, clr, en, d.
  - Parallel output q.
  - The top level instantiates it and contains the FSM, counter and handshake logic.
- The top level holds the operand register separately, so the shift register is free to restart during HOLD.

## Test plan
- Reset, then start, then strobes 1,0,0,1,1,0,0,1 on consecutive cycles with out_ready=0:
  - operand=8'b1001_1001 and out_valid=1 in the cycle after the 8th strobe.
  - bit_count=8 and busy=0.
- Frame for 8'hF0 (bits 0,0,0,0,1,1,1,1) with 2-cycle bit_valid gaps between strobes, then out_ready held 0 for 3 cycles and raised to 1 for 1 cycle:
  - operand stays at 8'hF0 and out_valid stays at 1 through the 3 stall cycles.
  - out_valid falls and state returns to IDLE after the accept edge.
- Mid-frame restart: send 3 bits, pulse start, then send 8'hFF:
  - operand=8'hFF.
  - bit_count reads 0 in the cycle after start.
- Overrun: after 8'h00 completes, drive bit_valid=1 for 1 cycle with out_ready=0:
  - overrun=1 and operand stays 8'h00.
  - The next start clears overrun.
- Reset mid-frame: assert rst_n=0 after 5 strobes:
  - All outputs read 0 and state is IDLE.
  - A new 8'h3C frame then completes correctly.
- Back-to-back: start asserted together with out_ready=1 in HOLD:
  - state goes directly to LOAD (busy=1).
  - The second operand 8'hA5 arrives WIDTH cycles later.
